// File: rtl/cla_queue_mp.sv
// Multi-port clause-list queue: node buffer plus signed-literal head table,
// serving NUM_ENG BCP engines with 1-cycle lookup and node-read ports.
module cla_queue_mp #(
  parameter int DEPTH       = 16,
  parameter int NODE_W      = 64,
  parameter int LIT_IDX_MAX = 32,
  parameter int NUM_ENG     = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LIT_W  = $clog2(LIT_IDX_MAX) + 1,
  localparam int HEAD_W = PTR_W + 1,
  localparam int HIDX_W = $clog2(2 * LIT_IDX_MAX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       load_done,
  input  logic                       push,
  input  logic [NODE_W-1:0]          node_in,
  output logic                       push_ready,
  input  logic                       head_we,
  input  logic [HIDX_W-1:0]          head_widx,
  input  logic [HEAD_W-1:0]          head_wdata,
  output logic [PTR_W:0]             count,
  output logic                       overflow,
  input  logic [NUM_ENG-1:0]         uc_valid,
  input  logic [NUM_ENG*LIT_W-1:0]   uc_lit,
  output logic [NUM_ENG-1:0]         uc_ready,
  output logic [NUM_ENG-1:0]         ip_valid,
  output logic [NUM_ENG-1:0]         ip_hit,
  output logic [NUM_ENG*PTR_W-1:0]   ip_ptr,
  input  logic [NUM_ENG-1:0]         rd_en,
  input  logic [NUM_ENG*PTR_W-1:0]   rd_idx,
  output logic [NUM_ENG-1:0]         rd_valid,
  output logic [NUM_ENG*NODE_W-1:0]  rd_node
);

  localparam int HEAD_N = 2 * LIT_IDX_MAX;

  typedef enum logic [0:0] {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  state;
  logic [NODE_W-1:0]       buffer [DEPTH];
  logic [HEAD_W-1:0]       head   [HEAD_N];
  logic                    full;
  logic                    do_push;

  // Map a signed literal to {legal, head index}; positive literals use the
  // lower half, negated literals the upper half. Illegal literals map to 0.
  function automatic logic [HIDX_W:0] lit_index(input logic [LIT_W-1:0] lit);
    logic [LIT_W-1:0]  mag;
    logic              legal;
    logic [HIDX_W-1:0] idx;
    mag   = lit[LIT_W-1] ? (-lit) : lit;
    legal = (lit != {LIT_W{1'b0}}) && (mag < LIT_W'(LIT_IDX_MAX));
    idx   = lit[LIT_W-1] ? (HIDX_W'(mag) + HIDX_W'(LIT_IDX_MAX)) : HIDX_W'(mag);
    return legal ? {1'b1, idx} : {1'b0, {HIDX_W{1'b0}}};
  endfunction

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign push_ready = (state == S_LOAD) && !full;
  assign uc_ready   = {NUM_ENG{state == S_RUN}};
  assign do_push    = rst_n && !flush && push && push_ready;

  // Node storage has no reset; contents past count are meaningless.
  always_ff @(posedge clk) begin
    if (do_push) begin
      buffer[count[PTR_W-1:0]] <= node_in;
    end
  end

  // Control state, head table and the registered engine responses.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state    <= S_LOAD;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < HEAD_N; i++) begin
        head[i] <= {1'b1, {PTR_W{1'b0}}};
      end
      ip_valid <= '0;
      ip_hit   <= '0;
      ip_ptr   <= '0;
      rd_valid <= '0;
      rd_node  <= '0;
    end else begin
      if (push && state == S_LOAD) begin
        if (!full) begin
          count <= count + (PTR_W+1)'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (head_we) begin
        head[head_widx] <= head_wdata;
      end
      if (state == S_LOAD && load_done) begin
        state <= S_RUN;
      end
      // Lookups read the head table before this edge's write lands.
      for (int e = 0; e < NUM_ENG; e++) begin
        if (uc_valid[e] && state == S_RUN) begin
          logic [HIDX_W:0]   li;
          logic [HEAD_W-1:0] ent;
          li  = lit_index(uc_lit[e*LIT_W +: LIT_W]);
          ent = head[li[HIDX_W-1:0]];
          ip_valid[e] <= 1'b1;
          if (li[HIDX_W] && !ent[PTR_W]) begin
            ip_hit[e]                <= 1'b1;
            ip_ptr[e*PTR_W +: PTR_W] <= ent[PTR_W-1:0];
          end else begin
            ip_hit[e]                <= 1'b0;
            ip_ptr[e*PTR_W +: PTR_W] <= '0;
          end
        end else begin
          ip_valid[e] <= 1'b0;
        end
      end
      rd_valid <= rd_en;
      for (int e = 0; e < NUM_ENG; e++) begin
        if (rd_en[e]) begin
          rd_node[e*NODE_W +: NODE_W] <= buffer[rd_idx[e*PTR_W +: PTR_W]];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_queue_mp.sv
// Self-checking bench for cla_queue_mp: table-driven lookups and node reads
// checked through expectation queues, plus hand-written corner sequences.
module tb_cla_queue_mp;

  localparam int DEPTH = 16;
  localparam int NW = 64;
  localparam int LM = 32;
  localparam int NE = 2;
  localparam int PW = 4;
  localparam int LW = 6;
  localparam int HW = 5;
  localparam int XW = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             load_done = 1'b0;
  logic             push = 1'b0;
  logic [NW-1:0]    node_in = '0;
  logic             push_ready;
  logic             head_we = 1'b0;
  logic [XW-1:0]    head_widx = '0;
  logic [HW-1:0]    head_wdata = '0;
  logic [PW:0]      count;
  logic             overflow;
  logic [NE-1:0]    uc_valid = '0;
  logic [NE*LW-1:0] uc_lit = '0;
  logic [NE-1:0]    uc_ready;
  logic [NE-1:0]    ip_valid;
  logic [NE-1:0]    ip_hit;
  logic [NE*PW-1:0] ip_ptr;
  logic [NE-1:0]    rd_en = '0;
  logic [NE*PW-1:0] rd_idx = '0;
  logic [NE-1:0]    rd_valid;
  logic [NE*NW-1:0] rd_node;

  cla_queue_mp #(.DEPTH(DEPTH), .NODE_W(NW), .LIT_IDX_MAX(LM), .NUM_ENG(NE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .load_done(load_done),
    .push(push), .node_in(node_in), .push_ready(push_ready),
    .head_we(head_we), .head_widx(head_widx), .head_wdata(head_wdata),
    .count(count), .overflow(overflow),
    .uc_valid(uc_valid), .uc_lit(uc_lit), .uc_ready(uc_ready),
    .ip_valid(ip_valid), .ip_hit(ip_hit), .ip_ptr(ip_ptr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_node(rd_node)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] uv;
    logic [5:0] l0;
    logic [5:0] l1;
    logic [1:0] ev;
    logic [1:0] eh;
    logic [3:0] p0;
    logic [3:0] p1;
  } lk_t;

  typedef struct {
    int          eng;
    logic [63:0] node;
    bit          cd;
  } rx_t;

  lk_t         lq[$];
  rx_t         rq[$];
  lk_t         tbl[8];
  logic [63:0] mbuf[DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [63:0] nv(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0000_0001_0001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_push(input int slot, input logic [63:0] d);
    push = 1'b1;
    node_in = d;
    tick();
    push = 1'b0;
    if (slot >= 0) mbuf[slot] = d;
  endtask

  task automatic hw(input int idx, input logic [4:0] d);
    head_we = 1'b1;
    head_widx = XW'(idx);
    head_wdata = d;
    tick();
    head_we = 1'b0;
  endtask

  task automatic lookup(input lk_t v, input string nm);
    lk_t r;
    uc_valid = v.uv;
    uc_lit = {v.l1, v.l0};
    lq.push_back(v);
    tick();
    uc_valid = '0;
    if (lq.size() == 0) begin
      chk({nm, "_sbq"}, 64'd0, 64'd1);
    end else begin
      r = lq.pop_front();
      chk({nm, "_valid"}, 64'(ip_valid), 64'(r.ev));
      chk({nm, "_hit"}, 64'(ip_hit), 64'(r.eh));
      chk({nm, "_ptr0"}, 64'(ip_ptr[3:0]), 64'(r.p0));
      chk({nm, "_ptr1"}, 64'(ip_ptr[7:4]), 64'(r.p1));
    end
  endtask

  task automatic rd(input logic [1:0] en, input int i0, input int i1, input string nm);
    rx_t r;
    rd_en = en;
    rd_idx = {PW'(i1), PW'(i0)};
    if (en[0]) rq.push_back('{0, (i0 < DEPTH) ? mbuf[i0] : 64'd0, i0 < 4});
    if (en[1]) rq.push_back('{1, (i1 < DEPTH) ? mbuf[i1] : 64'd0, i1 < 4});
    tick();
    rd_en = '0;
    chk({nm, "_rvalid"}, 64'(rd_valid), 64'(en));
    while (rq.size() > 0) begin
      r = rq.pop_front();
      if (r.cd) chk({nm, "_node"}, rd_node[r.eng*NW +: NW], r.node);
    end
  endtask

  initial begin
    tbl[0] = '{2'b11, 6'd3,  6'h3D, 2'b11, 2'b11, 4'd5,  4'd9};
    tbl[1] = '{2'b11, 6'd7,  6'd10, 2'b11, 2'b10, 4'd0,  4'd2};
    tbl[2] = '{2'b11, 6'd0,  6'h20, 2'b11, 2'b00, 4'd0,  4'd0};
    tbl[3] = '{2'b11, 6'h21, 6'h1F, 2'b11, 2'b01, 4'd15, 4'd0};
    tbl[4] = '{2'b11, 6'd3,  6'd3,  2'b11, 2'b11, 4'd5,  4'd5};
    tbl[5] = '{2'b10, 6'd3,  6'd10, 2'b10, 2'b11, 4'd5,  4'd2};
    tbl[6] = '{2'b01, 6'h3D, 6'd7,  2'b01, 2'b11, 4'd9,  4'd2};
    tbl[7] = '{2'b00, 6'd3,  6'd3,  2'b00, 2'b11, 4'd9,  4'd2};

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_pready", 64'(push_ready), 64'd1);
    chk("rst_ucready", 64'(uc_ready), 64'd0);
    chk("rst_ipvalid", 64'(ip_valid), 64'd0);
    chk("rst_rdvalid", 64'(rd_valid), 64'd0);
    chk("rst_rdnode", rd_node[63:0] | rd_node[127:64], 64'd0);

    // Lookup in LOAD is refused
    lookup('{2'b11, 6'd3, 6'd3, 2'b00, 2'b00, 4'd0, 4'd0}, "load_uc");

    // Fill A,B,C and heads; last cycle combines push, head write and load_done
    for (int i = 0; i < 3; i++) do_push(i, nv(i));
    chk("ld_count", 64'(count), 64'd3);
    chk("ld_pready", 64'(push_ready), 64'd1);
    chk("ld_ovf", 64'(overflow), 64'd0);
    chk("ld_ucready", 64'(uc_ready), 64'd0);
    hw(3, 5'b0_0101);
    hw(3 + LM, 5'b0_1001);
    hw(10, 5'b0_0010);
    head_we = 1'b1; head_widx = XW'(63); head_wdata = 5'b0_1111;
    load_done = 1'b1;
    do_push(3, nv(3));
    head_we = 1'b0; load_done = 1'b0;
    chk("run_count", 64'(count), 64'd4);
    chk("run_pready", 64'(push_ready), 64'd0);
    chk("run_ucready", 64'(uc_ready), 64'd3);

    // Push in RUN is ignored without overflow
    do_push(-1, nv(99));
    chk("runpush_count", 64'(count), 64'd4);
    chk("runpush_ovf", 64'(overflow), 64'd0);

    rd(2'b11, 1, 3, "rd_bd");
    rd(2'b01, 12, 0, "rd_oob");
    rd(2'b00, 0, 0, "rd_idle");

    for (int i = 0; i < 8; i++) lookup(tbl[i], $sformatf("lk%0d", i));

    // Head write to idx 3 alongside lookup of +3: old value seen, new next time
    head_we = 1'b1; head_widx = XW'(3); head_wdata = 5'b1_0000;
    lookup('{2'b01, 6'd3, 6'd0, 2'b01, 2'b11, 4'd5, 4'd2}, "rbw_old");
    head_we = 1'b0;
    lookup('{2'b01, 6'd3, 6'd0, 2'b01, 2'b10, 4'd0, 4'd2}, "rbw_new");

    // Flush beats load_done
    flush = 1'b1; load_done = 1'b1;
    tick();
    flush = 1'b0; load_done = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_pready", 64'(push_ready), 64'd1);
    chk("fl_ucready", 64'(uc_ready), 64'd0);
    chk("fl_ipvalid", 64'(ip_valid), 64'd0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) do_push(i, nv(100 + i));
    chk("full_count", 64'(count), 64'd16);
    chk("full_pready", 64'(push_ready), 64'd0);
    chk("full_ovf", 64'(overflow), 64'd0);
    do_push(-1, nv(116));
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_set", 64'(overflow), 64'd1);
    tick();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    rq.push_back('{0, nv(115), 1'b1});
    rq.push_back('{1, nv(100), 1'b1});
    rd_en = 2'b11; rd_idx = {PW'(0), PW'(15)};
    tick();
    rd_en = '0;
    chk("full_rvalid", 64'(rd_valid), 64'd3);
    while (rq.size() > 0) begin
      rx_t r;
      r = rq.pop_front();
      chk("full_node", rd_node[r.eng*NW +: NW], r.node);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl2_count", 64'(count), 64'd0);
    chk("fl2_ovf", 64'(overflow), 64'd0);
    chk("fl2_pready", 64'(push_ready), 64'd1);

    // Reset right after accepted lookups
    hw(3, 5'b0_0101);
    load_done = 1'b1; tick(); load_done = 1'b0;
    lookup('{2'b11, 6'd3, 6'd3, 2'b11, 2'b11, 4'd5, 4'd5}, "pre_rst");
    uc_valid = 2'b11; uc_lit = {6'd3, 6'd3};
    rst_n = 1'b0;
    tick();
    uc_valid = '0;
    chk("mrst_ipvalid", 64'(ip_valid), 64'd0);
    chk("mrst_iphit", 64'(ip_hit), 64'd0);
    chk("mrst_ucready", 64'(uc_ready), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mrst_ipvalid2", 64'(ip_valid), 64'd0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    lookup('{2'b11, 6'd3, 6'h3D, 2'b11, 2'b00, 4'd0, 4'd0}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_queue_mp.md
Name: cla_queue_mp

Overview:
- Multi-port clause-list queue: stores CNF clause nodes in a DEPTH-entry buffer and holds a dummy-head table (one entry per signed literal).
- Serves NUM_ENG BCP engines in parallel. Each engine gets one unit-clause lookup port and one node-read port, both registered with fixed 1-cycle latency.
- Adds an explicit LOAD/RUN mode FSM, per-entry head-table writes, full/overflow tracking and flush.
- Sits between the Carb/UCarb front end and the BCP engine array.

Parameters:
- DEPTH, 16, node buffer entries; power of two, at least 2.
- NODE_W, 64, width of one node word.
- LIT_IDX_MAX, 32, number of variables; the head table has 2*LIT_IDX_MAX entries.
- NUM_ENG, 2, number of BCP engine ports, at least 1.
- Derived: PTR_W=$clog2(DEPTH); LIT_W=$clog2(LIT_IDX_MAX)+1; HEAD_W=PTR_W+1; HIDX_W=$clog2(2*LIT_IDX_MAX).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  return to LOAD and clear all contents
- load_done  in  1  LOAD->RUN transition request
- push  in  1  append node_in at tail
- node_in  in  NODE_W  node data
- push_ready  out  1  high in LOAD when not full
- head_we  in  1  write one head-table entry
- head_widx  in  HIDX_W  head-table index to write
- head_wdata  in  HEAD_W  {null bit, ptr}; null bit is the MSB
- count  out  PTR_W+1  number of nodes stored
- overflow  out  1  sticky; set by a push while full
- uc_valid  in  NUM_ENG  per-engine lookup request
- uc_lit  in  NUM_ENG*LIT_W  per-engine literal, two's complement, MSB is the sign
- uc_ready  out  NUM_ENG  per-engine accept
- ip_valid  out  NUM_ENG  lookup response valid
- ip_hit  out  NUM_ENG  head entry non-null
- ip_ptr  out  NUM_ENG*PTR_W  initial pointer
- rd_en  in  NUM_ENG  node read request
- rd_idx  in  NUM_ENG*PTR_W  node index
- rd_valid  out  NUM_ENG  read data valid
- rd_node  out  NUM_ENG*NODE_W  node data

Behaviour:
- Reset: rst_n low at a clk edge is synchronous and active-low. Effects:
  - FSM goes to LOAD; tail/count=0; overflow=0.
  - Every head entry = {1'b1, 0} (null); buffer contents are don't-care.
  - All ip_*, rd_valid = 0 and rd_node = 0.
  - Reset mid-operation discards in-flight responses; no response appears the cycle after reset.
- FSM LOAD:
  - push_ready = (count<DEPTH); uc_ready = 0.
  - push && push_ready: buffer[tail] <= node_in, tail++, count++.
  - push && full: drop the node, set overflow.
  - head_we writes the entry at the next edge.
  - load_done -> RUN next cycle; a push or head_we in the same cycle is still applied.
- FSM RUN:
  - push_ready = 0; a push in RUN is ignored and does not set overflow.
  - head_we is still accepted (conflict updates).
  - uc_ready = all ones.
- flush: from any state -> LOAD next cycle with reset-equivalent clearing; overflow cleared. flush wins over load_done.
- Lookup, per engine e, RUN only:
  - lit = uc_lit[e]; sign = MSB.
  - Index: sign=0 -> idx = lit; sign=1 -> idx = (-lit) + LIT_IDX_MAX. Magnitude is computed in LIT_W bits.
  - lit=0 or magnitude>=LIT_IDX_MAX is illegal; response ip_hit=0.
  - Accept = uc_valid[e] && uc_ready[e]. The next cycle: ip_valid[e]=1, ip_hit[e] = !head[idx].null, ip_ptr[e] = head[idx].ptr if hit, else 0.
  - Without an accept: ip_valid[e]=0 next cycle; ip_ptr and ip_hit hold.
- Same-cycle head_we to idx and a lookup of idx: the lookup returns the OLD value (read-before-write).
- All NUM_ENG lookups proceed in parallel with no arbitration; identical literals on several ports each return a response.
- Node read, per engine, valid in any state:
  - rd_en[e] -> next cycle rd_valid[e]=1, rd_node[e]=buffer[rd_idx[e]].
  - rd_idx>=count is legal; rd_node is unspecified but rd_valid is still asserted.
  - Same-cycle push to an index and read of that index returns old data.
- Tail wrap: tail never wraps. After DEPTH pushes the block is full until flush or reset.

Test Plan:
- Reset then push 3 nodes (A,B,C) in LOAD -> count=3, push_ready=1, overflow=0. load_done, then rd_en[0] idx=1 -> rd_node[0]=B one cycle later with rd_valid[0]=1.
- DEPTH=16: push 17 nodes -> count=16, push_ready=0 after the 16th, overflow=1 sticky, node 17 not stored. flush -> count=0, overflow=0, FSM in LOAD.
- head_we idx=3 data {0,5}; idx=3+32 data {0,9}; RUN; uc_lit[0]=+3, uc_lit[1]=-3 in the same cycle -> next cycle ip_valid=2'b11, ip_hit=2'b11, ip_ptr[0]=5, ip_ptr[1]=9.
- Lookup of unwritten literal +7 -> ip_valid=1, ip_hit=0, ip_ptr=0. uc_valid in LOAD -> uc_ready=0, no response.
- In RUN: head_we idx=3 to {1,0} in the same cycle as a lookup of +3 -> response hit=1, ptr=5. Repeat the lookup a cycle later -> hit=0.
- Accept lookups on both engines, assert rst_n=0 the next cycle -> ip_valid=0 after reset, all heads null, FSM in LOAD.
